// File: rtl/osc_mixer_sequencer.sv
// -----------------------------------------------------------------------------
// osc_mixer_sequencer
//
// Steps a fixed-point phase accumulator for every oscillator, drives the
// integer part of each phase out as a BRAM playback index, waits out the BRAM
// read latency, then accumulates the enabled oscillators' samples one per
// cycle and emits a single saturated signed mix sample with a valid pulse.
//
// Ports
//   clk_in             system clock
//   rst_n_in           asynchronous active-low reset
//   sample_tick_in     1-cycle pulse at the audio sample rate, starts a mix
//   ui_update_trig_in  1-cycle pulse, zeroes every phase and index
//   wave_width_in      wave length in samples (phase wrap point)
//   osc_is_on_in       per-oscillator enable
//   osc_step_in        per-oscillator unsigned phase increment (int.frac)
//   osc_index_out      registered per-oscillator playback index
//   osc_data_in        per-oscillator sample data returned by the BRAMs
//   mix_out            saturated signed mix
//   mix_valid_out      1-cycle pulse, mix_out has just been updated
//   busy_out           high while a mix is in progress
//   overrun_out        1-cycle pulse, a tick arrived while busy and was dropped
// -----------------------------------------------------------------------------
module osc_mixer_sequencer #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 18,
  parameter int PHASE_FRAC      = 16,
  parameter int BRAM_LATENCY    = 2
) (
  input  logic                                                  clk_in,
  input  logic                                                  rst_n_in,
  input  logic                                                  sample_tick_in,
  input  logic                                                  ui_update_trig_in,
  input  logic [WW_WIDTH-1:0]                                   wave_width_in,
  input  logic [NUM_OSCILLATORS-1:0]                            osc_is_on_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH+PHASE_FRAC-1:0]   osc_step_in,
  output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]              osc_index_out,
  input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]          osc_data_in,
  output logic [SAMPLE_WIDTH-1:0]                               mix_out,
  output logic                                                  mix_valid_out,
  output logic                                                  busy_out,
  output logic                                                  overrun_out
);

  localparam int PW     = WW_WIDTH + PHASE_FRAC;
  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS);
  localparam int SEL_W  = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
  localparam int CNT_W  = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (SAMPLE_WIDTH - 1));

  typedef enum logic [2:0] {
    IDLE,
    ADVANCE,
    WAIT,
    SUM,
    OUT
  } state_t;

  state_t state, state_next;

  logic [NUM_OSCILLATORS-1:0][PW-1:0] phase;
  logic [NUM_OSCILLATORS-1:0][PW-1:0] phase_next;
  logic [NUM_OSCILLATORS-1:0]         on_q;
  logic [CNT_W-1:0]                   wait_cnt;
  logic [SEL_W-1:0]                   sel;
  logic signed [ACC_W-1:0]            acc;
  logic signed [ACC_W-1:0]            addend;
  logic [PW-1:0]                      wrap_w;
  logic [PW:0]                        sum_ext [NUM_OSCILLATORS];

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; ticks outside IDLE never alter the sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick_in) state_next = ADVANCE;
      ADVANCE: state_next = WAIT;
      WAIT:    if (wait_cnt == '0) state_next = SUM;
      SUM:     if (sel == SEL_W'(NUM_OSCILLATORS - 1)) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy_out = (state != IDLE);
  end

  // Candidate phases for the next ADVANCE. The sum is one bit wider so the
  // compare against the wrap point cannot overflow; a single subtract keeps
  // the remainder so no phase is lost at the wrap. A zero wave width pins
  // every phase to zero.
  always_comb begin
    wrap_w     = {wave_width_in, {PHASE_FRAC{1'b0}}};
    phase_next = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      sum_ext[i] = {1'b0, phase[i]} + {1'b0, osc_step_in[i]};
      if (!osc_is_on_in[i] || (wave_width_in == '0)) begin
        phase_next[i] = '0;
      end else if (sum_ext[i] >= {1'b0, wrap_w}) begin
        phase_next[i] = PW'(sum_ext[i] - {1'b0, wrap_w});
      end else begin
        phase_next[i] = sum_ext[i][PW-1:0];
      end
    end
  end

  // Off oscillators are masked because their BRAM port is disabled and the
  // data bus still shows whatever was last read.
  always_comb begin
    addend = '0;
    if (on_q[sel]) begin
      addend = {{(ACC_W - SAMPLE_WIDTH){osc_data_in[sel][SAMPLE_WIDTH-1]}}, osc_data_in[sel]};
    end
  end

  // Phase/index registers. The UI clear wins over an ADVANCE in the same
  // cycle and leaves the FSM alone.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase         <= '0;
      osc_index_out <= '0;
    end else if (ui_update_trig_in) begin
      phase         <= '0;
      osc_index_out <= '0;
    end else if (state == ADVANCE) begin
      phase <= phase_next;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        osc_index_out[i] <= phase_next[i][PW-1:PHASE_FRAC];
      end
    end
  end

  // Mix datapath: latch enables and clear the accumulator on ADVANCE, count
  // down the BRAM latency, sum one oscillator per cycle, then saturate.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      on_q          <= '0;
      wait_cnt      <= '0;
      sel           <= '0;
      acc           <= '0;
      mix_out       <= '0;
      mix_valid_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      overrun_out   <= sample_tick_in && (state != IDLE);
      mix_valid_out <= 1'b0;
      case (state)
        ADVANCE: begin
          on_q     <= osc_is_on_in;
          acc      <= '0;
          sel      <= '0;
          wait_cnt <= CNT_W'(BRAM_LATENCY - 1);
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        SUM: begin
          acc <= acc + addend;
          sel <= sel + 1'b1;
        end
        OUT: begin
          if (acc > SAT_MAX) begin
            mix_out <= SAT_MAX[SAMPLE_WIDTH-1:0];
          end else if (acc < SAT_MIN) begin
            mix_out <= SAT_MIN[SAMPLE_WIDTH-1:0];
          end else begin
            mix_out <= acc[SAMPLE_WIDTH-1:0];
          end
          mix_valid_out <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
